// File: rtl/board_input_ctrl_pkg.sv
// rtl/board_input_ctrl_pkg.sv - shared debouncer state enum, default parameters and counter sizing helper
package board_input_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_RUN_DIV         = 10000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 50000000;

    // A terminal count of 1 would give a zero-width counter; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_input_ctrl_btn_debounce.sv
// rtl/board_input_ctrl_btn_debounce.sv - button synchronizer and debounce FSM producing step_pulse
// AUTO_REPEAT_EN adds the held-button repeat counter.
module btn_debounce
    import board_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic step_pulse_o
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          btn_s1_q, btn_s2_q;
    deb_state_e    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RW = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q, rep_d;
`endif

    // The cycle that leaves IDLE/HELD already counts as the first stable cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!btn_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            HELD: begin
                if (!btn_s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = DW'(1);
                end
`ifdef AUTO_REPEAT_EN
                else if (rep_q == REP_LAST) begin
                    rep_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    rep_d = rep_q + RW'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                if (btn_s2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
                    rep_d   = '0;
`endif
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            btn_s1_q <= btn_i;
            btn_s2_q <= btn_s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
`ifdef AUTO_REPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    assign step_pulse_o = pulse_q;

endmodule

// File: rtl/board_input_ctrl.sv
// rtl/board_input_ctrl.sv - board button/switch front end: debounced step, run divider, switch snapshot
// Define AUTO_REPEAT_EN to enable held-button auto-repeat.
module board_input_ctrl
    import board_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic        clk100MHZ,
    input  logic        rst_n,
    input  logic        BTNC,
    input  logic [15:0] SW,
    output logic        cpu_en,
    output logic        step_pulse,
    output logic [15:0] sw_data,
    output logic        sw_valid,
    input  logic        sw_ack,
    output logic [15:0] press_count
);

    localparam int unsigned RDW = cnt_width(RUN_DIV);
    localparam logic [RDW-1:0] RUN_LAST = RDW'(RUN_DIV - 1);

    logic [15:0]    sw_s1_q, sw_s2_q;
    logic           run_mode;
    logic           mode_prev_q;
    logic [RDW-1:0] run_cnt_q, run_cnt_d;
    logic           run_tick_q, run_tick_d;
    logic [15:0]    sw_data_q, sw_data_d;
    logic           sw_valid_q, sw_valid_d;
    logic [15:0]    press_q, press_d;
    logic           step;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
    ) u_btn_debounce (
        .clk_i        (clk100MHZ),
        .rst_ni       (rst_n),
        .btn_i        (BTNC),
        .step_pulse_o (step)
    );

    assign run_mode = sw_s2_q[1];

    // Divider is held at zero outside run mode and restarts on the cycle the synced mode flips.
    always_comb begin
        run_cnt_d  = run_cnt_q;
        run_tick_d = 1'b0;
        if (!run_mode || (run_mode != mode_prev_q)) begin
            run_cnt_d = '0;
        end else if (run_cnt_q == RUN_LAST) begin
            run_cnt_d  = '0;
            run_tick_d = 1'b1;
        end else begin
            run_cnt_d = run_cnt_q + RDW'(1);
        end
    end

    // A capture outranks a simultaneous acknowledge so a fresh snapshot is never dropped.
    always_comb begin
        sw_data_d  = sw_data_q;
        sw_valid_d = sw_valid_q;
        press_d    = press_q;
        if (step) begin
            sw_data_d  = sw_s2_q;
            sw_valid_d = 1'b1;
            press_d    = press_q + 16'd1;
        end else if (sw_ack && sw_valid_q) begin
            sw_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            mode_prev_q <= 1'b0;
            run_cnt_q   <= '0;
            run_tick_q  <= 1'b0;
            sw_data_q   <= '0;
            sw_valid_q  <= 1'b0;
            press_q     <= '0;
        end else begin
            sw_s1_q     <= SW;
            sw_s2_q     <= sw_s1_q;
            mode_prev_q <= run_mode;
            run_cnt_q   <= run_cnt_d;
            run_tick_q  <= run_tick_d;
            sw_data_q   <= sw_data_d;
            sw_valid_q  <= sw_valid_d;
            press_q     <= press_d;
        end
    end

    assign cpu_en      = run_mode ? run_tick_q : step;
    assign step_pulse  = step;
    assign sw_data     = sw_data_q;
    assign sw_valid    = sw_valid_q;
    assign press_count = press_q;

endmodule

// File: tb/tb_board_input_ctrl.sv
// tb/tb_board_input_ctrl.sv - directed self-checking bench for board_input_ctrl
module tb_board_input_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        BTNC;
    logic [15:0] SW;
    logic        cpu_en;
    logic        step_pulse;
    logic [15:0] sw_data;
    logic        sw_valid;
    logic        sw_ack;
    logic [15:0] press_count;

    int n_total = 0;
    int n_bad   = 0;
    int n_step  = 0;
    int n_cpu   = 0;

    always #5 clk = ~clk;

    board_input_ctrl #(
        .DEBOUNCE_CYCLES (8),
        .RUN_DIV         (5),
        .REPEAT_CYCLES   (10)
    ) dut (
        .clk100MHZ   (clk),
        .rst_n       (rst_n),
        .BTNC        (BTNC),
        .SW          (SW),
        .cpu_en      (cpu_en),
        .step_pulse  (step_pulse),
        .sw_data     (sw_data),
        .sw_valid    (sw_valid),
        .sw_ack      (sw_ack),
        .press_count (press_count)
    );

    always @(negedge clk) begin
        if (step_pulse === 1'b1) n_step++;
        if (cpu_en === 1'b1) n_cpu++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(output int n);
        n = -1;
        for (int i = 1; i <= 40 && n < 0; i++) begin
            tick();
            if (step_pulse === 1'b1) n = i;
        end
    endtask

    task automatic settle();
        repeat (14) tick();
    endtask

    int lat, s0, c0, first, last, gaps, np, released, reps;
    int exp_reps;

    initial begin
`ifdef AUTO_REPEAT_EN
        exp_reps = 4;
`else
        exp_reps = 0;
`endif
        rst_n  = 1'b0;
        BTNC   = 1'b0;
        SW     = 16'h0000;
        sw_ack = 1'b0;
        repeat (2) tick();
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_step", step_pulse, 0);
        chk("rst_sw_valid", sw_valid, 0);
        chk("rst_sw_data", sw_data, 0);
        chk("rst_count", press_count, 0);
        rst_n = 1'b1;
        tick();

        // bounce then stable press
        s0 = n_step;
        for (int i = 0; i < 30; i++) begin
            BTNC = ((i / 3) % 2) == 0;
            tick();
        end
        chk("bounce_no_pulse", n_step - s0, 0);
        BTNC = 1'b1;
        s0 = n_step;
        c0 = n_cpu;
        wait_pulse(lat);
        chk("deb_latency", lat, 10);
        BTNC = 1'b0;
        settle();
        chk("deb_one_pulse", n_step - s0, 1);
        chk("deb_cpu_en", n_cpu - c0, 1);
        chk("deb_count", press_count, 1);

        // acknowledge behaviour and a clean step-mode capture
        sw_ack = 1'b1; tick(); sw_ack = 1'b0;
        chk("ack_clear", sw_valid, 0);
        sw_ack = 1'b1; tick(); sw_ack = 1'b0;
        chk("ack_idle", sw_valid, 0);
        SW = 16'h00A5;
        repeat (3) tick();
        BTNC = 1'b1;
        wait_pulse(lat);
        chk("step_cpu_en", cpu_en, 1);
        chk("step_pulse_hi", step_pulse, 1);
        BTNC = 1'b0;
        tick();
        chk("step_one_cycle", {cpu_en, step_pulse}, 0);
        chk("sw_data_a5", sw_data, 16'h00A5);
        chk("sw_valid_set", sw_valid, 1);
        sw_ack = 1'b1; tick(); sw_ack = 1'b0;
        chk("sw_valid_acked", sw_valid, 0);
        settle();

        // overwrite, then ack coincident with a new capture
        SW = 16'h0F00;
        repeat (3) tick();
        BTNC = 1'b1;
        wait_pulse(lat);
        BTNC = 1'b0;
        settle();
        chk("first_cap_valid", sw_valid, 1);
        chk("first_cap_data", sw_data, 16'h0F00);
        SW = 16'h1234;
        repeat (3) tick();
        BTNC = 1'b1;
        wait_pulse(lat);
        chk("coinc_seen", lat > 0, 1);
        sw_ack = 1'b1;
        BTNC = 1'b0;
        tick();
        sw_ack = 1'b0;
        chk("coinc_valid", sw_valid, 1);
        chk("coinc_data", sw_data, 16'h1234);
        chk("count_4", press_count, 4);
        settle();

        // run mode: divider grid unaffected by a press
        SW = 16'h0002;
        BTNC = 1'b1;
        first = -1; last = -1; gaps = 0; np = 0; released = 0;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (step_pulse === 1'b1 && released == 0) begin
                BTNC = 1'b0;
                released = 1;
            end
            if (cpu_en === 1'b1) begin
                if (first < 0) first = i;
                else if (i - last != 5) gaps++;
                last = i;
                np++;
            end
        end
        chk("run_press_seen", released, 1);
        chk("run_first", first, 8);
        chk("run_gaps", gaps, 0);
        chk("run_pulses", np, 6);
        chk("run_count", press_count, 5);
        repeat (10) tick();
        SW = 16'h0000;
        repeat (3) tick();
        c0 = n_cpu;
        repeat (20) tick();
        chk("step_quiet", n_cpu - c0, 0);
        BTNC = 1'b1;
        c0 = n_cpu;
        wait_pulse(lat);
        chk("step_after_run", cpu_en, 1);
        BTNC = 1'b0;
        settle();
        chk("step_after_run_n", n_cpu - c0, 1);

        // reset during PRESS_WAIT with the button still held
        BTNC = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_count", press_count, 0);
        chk("rst_mid_valid", sw_valid, 0);
        chk("rst_mid_data", sw_data, 0);
        chk("rst_mid_step", step_pulse, 0);
        tick();
        rst_n = 1'b1;
        wait_pulse(lat);
        chk("rst_relatch", lat, 10);
        BTNC = 1'b0;
        settle();
        chk("rst_relatch_count", press_count, 1);

        // long hold for auto-repeat
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        BTNC = 1'b1;
        wait_pulse(lat);
        chk("hold_latency", lat, 10);
        reps = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (step_pulse === 1'b1) reps++;
        end
        BTNC = 1'b0;
        settle();
        chk("hold_repeats", reps, exp_reps);
        chk("hold_count", press_count, 1 + exp_reps);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
